lcd_timing_gen: RTL
===================

LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- H_SYNC, 4, hsync pulse width in pixel clocks
- H_BP, 43, horizontal back porch
- H_ACTIVE, 480, active pixels per line
- H_FP, 8, horizontal front porch
- V_SYNC, 4, vsync pulse width in lines
- V_BP, 12, vertical back porch
- V_ACTIVE, 272, active lines
- V_FP, 8, vertical front porch
REQ-002 Ports (name, direction, width, meaning), one per line:
- PixelClk, in, 1, 9 MHz pixel clock from the video PLL
- nRST, in, 1, asynchronous active-low reset
- pattern_sel, in, 2, test pattern select
- LCD_HSYNC, out, 1, horizontal sync, active low
- LCD_VSYNC, out, 1, vertical sync, active low
- LCD_DEN, out, 1, data enable, active high
- LCD_R, out, 5, red
- LCD_G, out, 6, green
- LCD_B, out, 5, blue
- pix_x, out, 10, active pixel column
- pix_y, out, 9, active line
- frame_start, out, 1, single-cycle first-active-pixel strobe
REQ-003 One clock (PixelClk); reset is asynchronous and active-low (nRST); all state SHALL be clocked on the PixelClk rising edge.

Function
REQ-004 H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (535); V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP (296).
REQ-005 Internal h_cnt (10 bit) SHALL increment every cycle and wrap from H_TOTAL-1 to 0.
REQ-006 Internal v_cnt (9 bit) SHALL increment only when h_cnt wraps, and SHALL itself wrap from V_TOTAL-1 to 0 on that same cycle.
REQ-007 Every output SHALL be a registered decode of the counter values of the previous cycle: one-cycle latency, no combinational path to outputs.
REQ-008 LCD_HSYNC SHALL be low while h_cnt < H_SYNC, and high otherwise.
REQ-009 LCD_VSYNC SHALL be low while v_cnt < V_SYNC, and high otherwise.
REQ-010 LCD_DEN SHALL be high only when both of these hold:
- H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE
- V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACTIVE
REQ-011 pix_x and pix_y SHALL behave as follows:
- while DEN is high: pix_x = h_cnt-(H_SYNC+H_BP) and pix_y = v_cnt-(V_SYNC+V_BP), cycle-aligned with LCD_DEN and RGB
- while DEN is low: both SHALL read 0
REQ-012 frame_start SHALL pulse high for exactly one cycle, coincident with the first DEN cycle of each frame (pix_x=0, pix_y=0).
REQ-013 An active pattern register SHALL load pattern_sel only on the cycle h_cnt and v_cnt both wrap to 0, so a mid-frame change never alters the current frame.
REQ-014 Pattern 0 (colour bars) SHALL use eight 60-pixel bars chosen by comparisons, no divider:
- order: white, yellow, cyan, green, magenta, red, blue, black
- full scale = R 31, G 63, B 31
REQ-015 Pattern 1 (grid) SHALL be white where pix_x[4:0]==0, pix_y[4:0]==0, pix_x==H_ACTIVE-1 or pix_y==V_ACTIVE-1, and black elsewhere.
REQ-016 Pattern 2 (gradient) SHALL output R=pix_x[8:4], G=pix_x[8:3], B=pix_y[8:4].
REQ-017 Pattern 3 (solid) SHALL output R=0, G=0, B=31.
REQ-018 LCD_R, LCD_G and LCD_B SHALL be 0 whenever LCD_DEN is low.

Reset
REQ-019 While nRST is low, the block SHALL hold the following values, asynchronously and regardless of PixelClk:
- LCD_HSYNC=1, LCD_VSYNC=1
- LCD_DEN=0, frame_start=0
- RGB, pix_x and pix_y = 0
- h_cnt, v_cnt and the active pattern register = 0
REQ-020 After nRST deasserts, counting SHALL begin at h_cnt=v_cnt=0, and the first registered output update SHALL show LCD_HSYNC and LCD_VSYNC low.
REQ-021 Asserting nRST mid-line or mid-frame SHALL abort the frame immediately, with no partial-line completion.

Verification
REQ-022 Release nRST -> LCD_HSYNC low for 4 cycles every 535 cycles, and LCD_VSYNC low for 2140 cycles every 158360 cycles.
REQ-023 Run one frame -> exactly 272 DEN runs of 480 cycles each, and the first DEN occurs 47 cycles after the falling edge of the hsync pulse of line 16.
REQ-024 pattern_sel=0 -> pix_x=59 gives RGB (31,63,31), pix_x=60 gives (31,63,0), pix_x=479 gives (0,0,0), and RGB is 0 outside DEN.
REQ-025 Change pattern_sel from 0 to 1 at pix_y=100 -> the rest of the frame stays colour bars; after the next frame_start, pix_x=32, pix_y=5 gives white and pix_x=33, pix_y=5 gives black.
REQ-026 Assert nRST at pix_x=200, pix_y=50 -> all outputs go to reset values without waiting for a clock edge; after release, the timing of REQ-022 restarts from cycle 0.
REQ-027 pattern_sel=2 -> at pix_x=479, pix_y=271 the outputs are RGB (29,59,16) and frame_start is exactly one cycle wide per frame.

Source files
------------

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: RGB LCD timing generator with built-in test patterns.
//   PixelClk     - pixel clock, all state on its rising edge
//   nRST         - asynchronous active-low reset
//   pattern_sel  - test pattern (0 bars, 1 grid, 2 gradient, 3 solid blue),
//                  taken only at the frame boundary
//   LCD_HSYNC/LCD_VSYNC - active-low syncs
//   LCD_DEN      - active-high data enable
//   LCD_R/G/B    - 5/6/5 colour, zero outside the active area
//   pix_x/pix_y  - active pixel coordinates, zero outside the active area
//   frame_start  - one-cycle strobe on the first active pixel of a frame
module lcd_timing_gen #(
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 43,
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 8,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 12,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 8
) (
    input  logic       PixelClk,
    input  logic       nRST,
    input  logic [1:0] pattern_sel,
    output logic       LCD_HSYNC,
    output logic       LCD_VSYNC,
    output logic       LCD_DEN,
    output logic [4:0] LCD_R,
    output logic [5:0] LCD_G,
    output logic [4:0] LCD_B,
    output logic [9:0] pix_x,
    output logic [8:0] pix_y,
    output logic       frame_start
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS_END = 10'(H_SYNC);
    localparam logic [9:0] HA_BEG = 10'(H_SYNC + H_BP);
    localparam logic [9:0] HA_END = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
    localparam logic [8:0] VS_END = 9'(V_SYNC);
    localparam logic [8:0] VA_BEG = 9'(V_SYNC + V_BP);
    localparam logic [8:0] VA_END = 9'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [8:0] Y_LAST = 9'(V_ACTIVE - 1);

    logic [9:0]  h_cnt_q, h_cnt_d, x_q, x_d;
    logic [8:0]  v_cnt_q, v_cnt_d, y_q, y_d;
    logic [1:0]  pat_q, pat_d;
    logic        hs_q, hs_d, vs_q, vs_d, den_q, den_d, fs_q, fs_d;
    logic [15:0] rgb_q, rgb_d, bars;
    logic [2:0]  bar;
    logic        h_wrap, v_wrap, white;

    always_comb begin
        h_wrap  = h_cnt_q == H_LAST;
        v_wrap  = v_cnt_q == V_LAST;
        h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
        v_cnt_d = h_wrap ? (v_wrap ? '0 : v_cnt_q + 9'd1) : v_cnt_q;
        // New pattern only takes effect from the first cycle of the next frame
        pat_d   = (h_wrap && v_wrap) ? pattern_sel : pat_q;
        hs_d    = h_cnt_q >= HS_END;
        vs_d    = v_cnt_q >= VS_END;
        den_d   = h_cnt_q >= HA_BEG && h_cnt_q < HA_END && v_cnt_q >= VA_BEG && v_cnt_q < VA_END;
        x_d     = den_d ? h_cnt_q - HA_BEG : '0;
        y_d     = den_d ? v_cnt_q - VA_BEG : '0;
        fs_d    = den_d && x_d == '0 && y_d == '0;
        // Bar index by threshold compares, so no divider is built
        bar     = '0;
        for (int i = 1; i < 8; i++)
            if (x_d >= 10'(i * BAR_W)) bar = 3'(i);
        // Bar order white..black maps to inverted index bits: R=~b1, G=~b2, B=~b0
        bars    = {{5{~bar[1]}}, {6{~bar[2]}}, {5{~bar[0]}}};
        white   = x_d[4:0] == '0 || y_d[4:0] == '0 || x_d == X_LAST || y_d == Y_LAST;
        rgb_d   = !den_d        ? 16'h0000 :
                  pat_q == 2'd0 ? bars :
                  pat_q == 2'd1 ? {16{white}} :
                  pat_q == 2'd2 ? {x_d[8:4], x_d[8:3], y_d[8:4]} :
                                  16'h001F;
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            pat_q   <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            den_q   <= 1'b0;
            fs_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            rgb_q   <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            pat_q   <= pat_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            den_q   <= den_d;
            fs_q    <= fs_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rgb_q   <= rgb_d;
        end
    end

    assign LCD_HSYNC   = hs_q;
    assign LCD_VSYNC   = vs_q;
    assign LCD_DEN     = den_q;
    assign frame_start = fs_q;
    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign LCD_R       = rgb_q[15:11];
    assign LCD_G       = rgb_q[10:5];
    assign LCD_B       = rgb_q[4:0];
endmodule
